rf_wr_arbiter: RTL and testbench

Write-port arbiter for the 32×32 register file. It shares the file's single write port (address, data, write enable, PC) between two sources. Port 0 is the main pipeline writeback. Port 1 is a multi-cycle unit (mult/div) writeback, and it is buffered. The block sits directly in front of the register file's write inputs and exports a pending-write mask for hazard detection.

---
 rtl/rf_arb_pkg.sv | 23 ++
 rtl/rf_arb_fifo.sv | 91 +++++++++
 rtl/rf_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and constants for the register-file write-port arbiter
package rf_arb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_P0,
        GNT_BUF
    } grant_e;

    // One-hot register decode used to build the pending-write mask.
    function automatic logic [31:0] reg_onehot(input logic [4:0] r);
        reg_onehot = 32'd1 << r;
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// rtl/rf_arb_fifo.sv - port-1 write buffer (FIFO of wr_req_t with per-entry valid bits)
//
// Ports:
//   clk, reset   clock, synchronous active-high reset (drops all entries)
//   push         enqueue push_data at the rising edge (ignored when full)
//   push_data    write request to enqueue
//   pop          dequeue the head at the rising edge (ignored when empty)
//   head         oldest buffered request
//   count        number of buffered entries
//   empty        no entries buffered
//   entry_vld    per-slot valid bit
//   entry_addr   per-slot destination register
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  wr_req_t                      push_data,
    input  logic                         pop,
    output wr_req_t                      head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty,
    output logic [DEPTH-1:0]             entry_vld,
    output logic [DEPTH-1:0][4:0]        entry_addr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wr_req_t         mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   cnt;
    logic [DEPTH-1:0] vld;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            vld  <= '0;
        end else begin
            if (push_ok) begin
                vld[wptr] <= 1'b1;
                wptr      <= wptr + 1'b1;
            end
            // push and pop never address the same slot: that needs empty or full.
            if (pop_ok) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    always_comb begin
        entry_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end

    assign head      = mem[rptr];
    assign count     = cnt;
    assign entry_vld = vld;

endmodule

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - two-source arbiter for the register file's single write port
//
// Port 0 (pipeline writeback) is unbuffered and zero-latency; port 1 (multi-cycle
// unit) goes through rf_arb_fifo. The buffer wins whenever port 0 has no real
// write, or by force once its head has lost STARVE_LIMIT consecutive cycles.
// Optional macro RF_ARB_TRACE_EN prints one trace line per register-file write.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   p0_valid/addr/data/pc       pipeline writeback request
//   p0_stall                    port-0 write held off this cycle
//   p1_valid/addr/data/pc       multi-cycle unit result
//   p1_ready                    buffer can accept
//   rf_we/addr/wd/pc            register-file write port
//   pending_mask                registers targeted by buffered writes
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_valid,
    input  logic [4:0]  p0_addr,
    input  logic [31:0] p0_data,
    input  logic [31:0] p0_pc,
    output logic        p0_stall,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [4:0]  p1_addr,
    input  logic [31:0] p1_data,
    input  logic [31:0] p1_pc,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wd,
    output logic [31:0] rf_pc,
    output logic [31:0] pending_mask
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);

    grant_e              grant;
    logic                p0_real;
    logic                buf_push;
    logic                buf_pop;
    wr_req_t             buf_in;
    wr_req_t             buf_head;
    logic [CW-1:0]       buf_count;
    logic                buf_empty;
    logic [DEPTH-1:0]    buf_vld;
    logic [DEPTH-1:0][4:0] buf_addr;
    logic [3:0]          starve_cnt;
    logic [31:0]         mask_raw;

    // Writes to $0 are architecturally no-ops and never take the port.
    assign p0_real = p0_valid && (p0_addr != REG_ZERO);

    // No pop-through: readiness depends only on the registered count.
    assign p1_ready = !reset && (buf_count < DEPTH_C);
    assign buf_push = p1_valid && p1_ready && (p1_addr != REG_ZERO);
    assign buf_in   = '{addr: p1_addr, data: p1_data, pc: p1_pc};

    rf_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (buf_push),
        .push_data  (buf_in),
        .pop        (buf_pop),
        .head       (buf_head),
        .count      (buf_count),
        .empty      (buf_empty),
        .entry_vld  (buf_vld),
        .entry_addr (buf_addr)
    );

    always_comb begin
        grant = GNT_IDLE;
        if (!reset) begin
            if (!buf_empty && (!p0_real || (starve_cnt == STARVE_MAX))) begin
                grant = GNT_BUF;
            end else if (p0_real) begin
                grant = GNT_P0;
            end
        end
    end

    assign buf_pop = (grant == GNT_BUF);

    always_comb begin
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_wd    = '0;
        rf_pc    = '0;
        p0_stall = 1'b0;
        case (grant)
            GNT_P0: begin
                rf_we   = 1'b1;
                rf_addr = p0_addr;
                rf_wd   = p0_data;
                rf_pc   = p0_pc;
            end
            GNT_BUF: begin
                rf_we    = 1'b1;
                rf_addr  = buf_head.addr;
                rf_wd    = buf_head.data;
                rf_pc    = buf_head.pc;
                // Only a forced grant can collide with a real port-0 write.
                p0_stall = p0_real;
            end
            default: ;
        endcase
    end

    // Counts consecutive losses of the buffer head; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset || buf_pop) begin
            starve_cnt <= '0;
        end else if (!buf_empty && (grant == GNT_P0) && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_comb begin
        mask_raw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (buf_vld[i]) begin
                mask_raw = mask_raw | reg_onehot(buf_addr[i]);
            end
        end
    end

    assign pending_mask = reset ? 32'd0 : (mask_raw & ~32'd1);

`ifdef RF_ARB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && rf_we) begin
            $display("@%08h: $%d <= %08h", rf_pc, rf_addr, rf_wd);
        end
    end
`else
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - self-checking bench for rf_wr_arbiter (DEPTH=2, STARVE_LIMIT=4)
module tb_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_valid;
    logic [4:0]  p0_addr;
    logic [31:0] p0_data;
    logic [31:0] p0_pc;
    logic        p0_stall;
    logic        p1_valid;
    logic        p1_ready;
    logic [4:0]  p1_addr;
    logic [31:0] p1_data;
    logic [31:0] p1_pc;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wd;
    logic [31:0] rf_pc;
    logic [31:0] pending_mask;

    always #5 clk = ~clk;

    rf_wr_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .p0_valid     (p0_valid),
        .p0_addr      (p0_addr),
        .p0_data      (p0_data),
        .p0_pc        (p0_pc),
        .p0_stall     (p0_stall),
        .p1_valid     (p1_valid),
        .p1_ready     (p1_ready),
        .p1_addr      (p1_addr),
        .p1_data      (p1_data),
        .p1_pc        (p1_pc),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_wd        (rf_wd),
        .rf_pc        (rf_pc),
        .pending_mask (pending_mask)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Expected register-file port contents, one entry per checked cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            n_chk++;
            if (rf_we !== mon_e.we || rf_addr !== mon_e.a || rf_wd !== mon_e.d || rf_pc !== mon_e.pc) begin
                n_fail++;
                $display("FAIL rf_port @%0t: got we=%b addr=%0d wd=%h pc=%h, expected we=%b addr=%0d wd=%h pc=%h",
                         $time, rf_we, rf_addr, rf_wd, rf_pc, mon_e.we, mon_e.a, mon_e.d, mon_e.pc);
            end
        end
    end

    task automatic step(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        sb.push_back('{we: we, a: a, d: d, pc: pc});
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        p0_valid = v; p0_addr = a; p0_data = d; p0_pc = pc;
    endtask

    task automatic set_p1(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        p1_valid = v; p1_addr = a; p1_data = d; p1_pc = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_p0(1'b1, 5'd3, 32'h11, 32'h10);
        set_p1(1'b1, 5'd4, 32'h22, 32'h20);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 5'd0, 32'd0, 32'd0);
            n_chk++;
            if (p0_stall !== 1'b0 || p1_ready !== 1'b0 || pending_mask !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got stall=%b ready=%b mask=%h, expected 0 0 00000000", p0_stall, p1_ready, pending_mask);
            end
            adv();
        end
        reset = 1'b0;
        set_p0(1'b0, 5'd0, 32'd0, 32'd0);
        set_p1(1'b0, 5'd0, 32'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 32'd0);
        n_chk++;
        if (p1_ready !== 1'b1 || pending_mask !== 32'd0 || p0_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got ready=%b mask=%h stall=%b, expected 1 00000000 0", p1_ready, pending_mask, p0_stall);
        end
        adv();
    endtask

    task automatic test_p1_basic();
        set_p1(1'b1, 5'd5, 32'h1234, 32'h100);
        step(1'b0, 5'd0, 32'd0, 32'd0);
        n_chk++;
        if (p1_ready !== 1'b1 || pending_mask !== 32'd0) begin
            n_fail++;
            $display("FAIL p1_accept: got ready=%b mask=%h, expected 1 00000000", p1_ready, pending_mask);
        end
        adv();
        set_p1(1'b0, 5'd0, 32'd0, 32'd0);
        step(1'b1, 5'd5, 32'h1234, 32'h100);
        n_chk++;
        if (pending_mask !== 32'h20) begin
            n_fail++;
            $display("FAIL p1_mask_set: got %h expected 00000020", pending_mask);
        end
        adv();
        step(1'b0, 5'd0, 32'd0, 32'd0);
        n_chk++;
        if (pending_mask !== 32'd0) begin
            n_fail++;
            $display("FAIL p1_mask_clear: got %h expected 00000000", pending_mask);
        end
        adv();
    endtask

    task automatic test_starve();
        logic [31:0] d;
        logic        exp_stall;
        for (int i = 0; i <= 6; i++) begin
            d = 32'h30 + 32'((i < 6) ? i : 5);
            set_p0(1'b1, 5'd3, d, 32'h200 + 32'((i < 6) ? i : 5));
            if (i == 0) set_p1(1'b1, 5'd7, 32'hAA, 32'h300);
            else        set_p1(1'b0, 5'd0, 32'd0, 32'd0);
            exp_stall = (i == 5);
            if (exp_stall) step(1'b1, 5'd7, 32'hAA, 32'h300);
            else           step(1'b1, 5'd3, d, 32'h200 + 32'((i < 6) ? i : 5));
            n_chk++;
            if (p0_stall !== exp_stall) begin
                n_fail++;
                $display("FAIL starve_stall c%0d: got %b expected %b", i, p0_stall, exp_stall);
            end
            if (i >= 1 && i <= 4) begin
                n_chk++;
                if (pending_mask !== 32'h80) begin
                    n_fail++;
                    $display("FAIL starve_mask c%0d: got %h expected 00000080", i, pending_mask);
                end
            end
            adv();
        end
        set_p0(1'b0, 5'd0, 32'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 32'd0);
        adv();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  b_addr [3];
        logic [31:0] b_data [3];
        int          acc;
        int          popped;
        int          k;
        logic        exp_stall;
        logic        exp_rdy;
        b_addr[0] = 5'd10; b_addr[1] = 5'd11; b_addr[2] = 5'd12;
        b_data[0] = 32'hA0; b_data[1] = 32'hB0; b_data[2] = 32'hC0;
        acc = 0; popped = 0; k = 0;
        for (int i = 0; i <= 16; i++) begin
            set_p0(1'b1, 5'd4, 32'h400 + 32'(k), 32'h4000 + 32'(k));
            if (acc < 3) set_p1(1'b1, b_addr[acc], b_data[acc], 32'h500 + 32'(acc));
            else         set_p1(1'b0, 5'd0, 32'd0, 32'd0);
            exp_stall = (i == 5) || (i == 10) || (i == 15);
            exp_rdy   = (i <= 1) || (i == 6);
            if (exp_stall) step(1'b1, b_addr[popped], b_data[popped], 32'h500 + 32'(popped));
            else           step(1'b1, 5'd4, 32'h400 + 32'(k), 32'h4000 + 32'(k));
            n_chk++;
            if (p0_stall !== exp_stall) begin
                n_fail++;
                $display("FAIL b2b_stall c%0d: got %b expected %b", i, p0_stall, exp_stall);
            end
            if (i <= 6) begin
                n_chk++;
                if (p1_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL b2b_ready c%0d: got %b expected %b", i, p1_ready, exp_rdy);
                end
            end
            if (p1_valid && exp_rdy) acc++;
            if (exp_stall) popped++;
            else           k++;
            adv();
        end
        set_p0(1'b0, 5'd0, 32'd0, 32'd0);
        set_p1(1'b0, 5'd0, 32'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 32'd0);
        adv();
    endtask

    task automatic test_zero_addr();
        set_p1(1'b1, 5'd9, 32'h99, 32'h600);
        step(1'b0, 5'd0, 32'd0, 32'd0);
        adv();
        set_p0(1'b1, 5'd0, 32'hDEAD, 32'h700);
        set_p1(1'b1, 5'd0, 32'hBEEF, 32'h604);
        step(1'b1, 5'd9, 32'h99, 32'h600);
        n_chk++;
        if (p0_stall !== 1'b0 || pending_mask !== 32'h200) begin
            n_fail++;
            $display("FAIL zero_p0_grant: got stall=%b mask=%h, expected 0 00000200", p0_stall, pending_mask);
        end
        adv();
        set_p1(1'b0, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 5'd0, 32'd0, 32'd0);
            n_chk++;
            if (p0_stall !== 1'b0 || pending_mask !== 32'd0 || p1_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL zero_discard c%0d: got stall=%b mask=%h ready=%b, expected 0 00000000 1", i, p0_stall, pending_mask, p1_ready);
            end
            adv();
        end
        set_p0(1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic test_reset_mid();
        set_p0(1'b1, 5'd1, 32'h70, 32'h800);
        set_p1(1'b1, 5'd20, 32'h2020, 32'h900);
        step(1'b1, 5'd1, 32'h70, 32'h800);
        adv();
        set_p0(1'b1, 5'd1, 32'h71, 32'h804);
        set_p1(1'b1, 5'd21, 32'h2121, 32'h904);
        step(1'b1, 5'd1, 32'h71, 32'h804);
        adv();
        set_p0(1'b1, 5'd1, 32'h72, 32'h808);
        set_p1(1'b0, 5'd0, 32'd0, 32'd0);
        step(1'b1, 5'd1, 32'h72, 32'h808);
        n_chk++;
        if (pending_mask !== 32'h0030_0000 || p1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_full: got mask=%h ready=%b, expected 00300000 0", pending_mask, p1_ready);
        end
        adv();
        reset = 1'b1;
        step(1'b0, 5'd0, 32'd0, 32'd0);
        n_chk++;
        if (pending_mask !== 32'd0 || p0_stall !== 1'b0 || p1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got mask=%h stall=%b ready=%b, expected 00000000 0 0", pending_mask, p0_stall, p1_ready);
        end
        adv();
        reset = 1'b0;
        set_p0(1'b0, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 5'd0, 32'd0, 32'd0);
            n_chk++;
            if (pending_mask !== 32'd0 || p1_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_after c%0d: got mask=%h ready=%b, expected 00000000 1", i, pending_mask, p1_ready);
            end
            adv();
        end
    endtask

    initial begin
        reset = 1'b1;
        set_p0(1'b0, 5'd0, 32'd0, 32'd0);
        set_p1(1'b0, 5'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        test_reset();
        test_p1_basic();
        test_starve();
        test_back_to_back();
        test_zero_addr();
        test_reset_mid();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
